// File: rtl/definitions.sv
// Shared datapath types for the ALU and its access arbiter: operand/result type,
// opcodes, the packed instruction record and the arbiter FSM state.
package definitions;
    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MULT = 2'd2, NOP = 2'd3} opcode_t;

    typedef enum logic {UNSIGNED = 1'b0, SIGNED = 1'b1} op_type_t;

    typedef struct packed {
        opcode_t  opc;
        op_type_t op_type;
        data_t    op_a;
        data_t    op_b;
    } instruction_t;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} alu_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit scanning
// upward from ptr+1 (mod N). Reusable for any shared resource.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // k runs 1..N so the previous winner is considered last.
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among N_REQ requesters.
// Optional macro ALU_ARB_MULT_2CYC_EN: MULT holds EXEC for two cycles.
module alu_arbiter
    import definitions::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  instruction_t [N_REQ-1:0] req_instr,
    output logic [N_REQ-1:0]         req_ready,
    output instruction_t             alu_instr,
    input  data_t                    alu_out,
    output logic                     rsp_valid,
    output data_t                    rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready,
    output logic                     busy,
    output logic [15:0]              done_cnt
);
    alu_arb_state_t  state_q, state_d;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic            capture;
`ifdef ALU_ARB_MULT_2CYC_EN
    logic            exec_cnt;
`endif

    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
        .req     (req_valid),
        .ptr     (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (|req_valid) state_d = EXEC;
            EXEC: begin
`ifdef ALU_ARB_MULT_2CYC_EN
                // First MULT cycle only lets the multiplier settle; capture on the second.
                if (alu_instr.opc == MULT && !exec_cnt) begin
                    state_d = EXEC;
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
`else
                capture = 1'b1;
                state_d = RESP;
`endif
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so nothing looks accepted while the block is held in reset.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_instr  <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            last_grant <= ID_W'(N_REQ - 1);
            done_cnt   <= '0;
`ifdef ALU_ARB_MULT_2CYC_EN
            exec_cnt   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (|req_valid) begin
                    alu_instr  <= req_instr[gnt_idx];
                    rsp_id     <= gnt_idx;
                    last_grant <= gnt_idx;
                end
                EXEC: if (capture) begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    done_cnt  <= done_cnt + 16'd1;
                end
                default: ;
            endcase
`ifdef ALU_ARB_MULT_2CYC_EN
            exec_cnt <= (state_q == EXEC) && !capture;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, table of single ops, round-robin,
// backpressure and reset during EXEC, with a behavioural ALU attached.
module tb_alu_arbiter;
    import definitions::*;

`ifdef ALU_ARB_MULT_2CYC_EN
    localparam int MULT_LAT = 3;
`else
    localparam int MULT_LAT = 2;
`endif

    logic               clk;
    logic               rst;
    logic [3:0]         req_valid;
    instruction_t [3:0] req_instr;
    logic [3:0]         req_ready;
    instruction_t       alu_instr;
    data_t              alu_out;
    logic               rsp_valid;
    data_t              rsp_data;
    logic [1:0]         rsp_id;
    logic               rsp_ready;
    logic               busy;
    logic [15:0]        done_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_done = '0;

    alu_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_instr (req_instr),
        .req_ready (req_ready),
        .alu_instr (alu_instr),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // Behavioural ALU
    always_comb begin
        alu_out = alu_instr.op_a;
        case (alu_instr.opc)
            ADD:  alu_out = alu_instr.op_a + alu_instr.op_b;
            SUB:  alu_out = alu_instr.op_a - alu_instr.op_b;
            MULT: alu_out = alu_instr.op_a * alu_instr.op_b;
            default: alu_out = alu_instr.op_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0] id;
        opcode_t    opc;
        data_t      a;
        data_t      b;
        data_t      exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_instr(input logic [1:0] id, input opcode_t opc, input data_t a, input data_t b);
        req_instr[id].opc     = opc;
        req_instr[id].op_type = UNSIGNED;
        req_instr[id].op_a    = a;
        req_instr[id].op_b    = b;
    endtask

    task automatic run_op(input logic [1:0] id, input opcode_t opc, input data_t a,
                          input data_t b, input data_t exp);
        int lat;
        int want_lat;
        want_lat = (opc == MULT) ? MULT_LAT : 2;
        set_instr(id, opc, a, b);
        req_valid = 4'b0001 << id;
        rsp_ready = 1'b1;
        #1;
        chk("grant", 64'(req_ready), 64'(4'b0001 << id));
        tick();
        req_valid = '0;
        chk("busy_exec", 64'(busy), 64'd1);
        chk("ready_exec", 64'(req_ready), 64'd0);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(want_lat));
        chk("rsp_data", 64'(rsp_data), 64'(exp));
        chk("rsp_id", 64'(rsp_id), 64'(id));
        exp_done++;
        tick();
        chk("done_cnt", 64'(done_cnt), 64'(exp_done));
        chk("rsp_clear", 64'(rsp_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'd2, ADD,  32'd5,          32'd3,          32'd8};
        vecs[1] = '{2'd0, SUB,  32'd5,          32'd3,          32'd2};
        vecs[2] = '{2'd3, MULT, 32'd12,         32'd3,          32'd36};
        vecs[3] = '{2'd1, ADD,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[4] = '{2'd2, SUB,  32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[5] = '{2'd3, MULT, 32'h0001_0000,  32'h0001_0000,  32'd0};

        // Reset held for two cycles with every requester pending
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_instr(2'(i), SUB, 32'd5, 32'd3);
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_alu_instr", 64'(|alu_instr), 64'd0);
        rst = 1'b0;
        #1;
        chk("first_grant", 64'(req_ready), 64'd1);
        req_valid = '0;
        tick();
        chk("withdrawn_idle", 64'(busy), 64'd0);

        // Table of single operations
        for (int v = 0; v < 6; v++)
            run_op(vecs[v].id, vecs[v].opc, vecs[v].a, vecs[v].b, vecs[v].exp);

        // Round-robin: everyone holds SUB 5,3; pointer now at 3, so order 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_instr(2'(i), SUB, 32'd5, 32'd3);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
            tick();
            chk("rr_exec_ready", 64'(req_ready), 64'd0);
            tick();
            chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rr_rsp_data", 64'(rsp_data), 64'd2);
            chk("rr_rsp_id", 64'(rsp_id), 64'(i % 4));
            exp_done++;
            tick();
            chk("rr_done_cnt", 64'(done_cnt), 64'(exp_done));
        end
        req_valid = '0;
        tick();

        // Backpressure: MULT 12,3 from requester 1 with rsp_ready low
        begin
            int lat;
            set_instr(2'd1, MULT, 32'd12, 32'd3);
            req_valid = 4'b0010;
            rsp_ready = 1'b0;
            #1;
            chk("bp_grant", 64'(req_ready), 64'b0010);
            tick();
            req_valid = 4'hF;
            lat = 1;
            while (!rsp_valid && lat < 8) begin
                tick();
                lat++;
            end
            chk("bp_latency", 64'(lat), 64'(MULT_LAT));
            for (int c = 0; c < 5; c++) begin
                chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
                chk("bp_rsp_data", 64'(rsp_data), 64'd36);
                chk("bp_rsp_id", 64'(rsp_id), 64'd1);
                chk("bp_req_ready", 64'(req_ready), 64'd0);
                chk("bp_done_hold", 64'(done_cnt), 64'(exp_done));
                tick();
            end
            rsp_ready = 1'b1;
            tick();
            req_valid = '0;
            exp_done++;
            chk("bp_done_cnt", 64'(done_cnt), 64'(exp_done));
            chk("bp_rsp_clear", 64'(rsp_valid), 64'd0);
            tick();
            tick();
            chk("bp_single_rsp", 64'(rsp_valid), 64'd0);
            chk("bp_done_final", 64'(done_cnt), 64'(exp_done));
        end

        // Config: MULT vs ADD latency
        run_op(2'd0, MULT, 32'd12, 32'd3, 32'd36);
        run_op(2'd0, ADD,  32'd5,  32'd3, 32'd8);

        // Reset while in EXEC aborts the transaction
        set_instr(2'd2, ADD, 32'd5, 32'd3);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("abort_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        chk("abort_in_exec", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done_cnt", 64'(done_cnt), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        req_valid = 4'hF;
        #1;
        chk("abort_next_grant", 64'(req_ready), 64'd1);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
